data_out_collect: RTL
=====================

DATA_OUT_COLLECT -- requirements
Module: data_out_collect

Interface
REQ-001 Parameter OUT_DIM, default `HID_DIM, is the number of result words per vector.
REQ-002 Parameter DW, default `N_LEN, is the width of one result word.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 run  input  1  one-cycle pulse that starts (or restarts) collection of a new vector.
REQ-006 in_valid  input  1  in_data holds a result word this cycle.
REQ-007 in_data  input  DW  one result word from the compute core.
REQ-008 out_ready  input  1  downstream accepts data_out this cycle.
REQ-009 valid  output  1  data_out holds a complete vector.
REQ-010 data_out  output  OUT_DIM*DW  assembled vector; slot k occupies bits [k*DW+DW-1 : k*DW].
REQ-011 busy  output  1  collection in progress.
REQ-012 err_overrun  output  1  sticky flag: a word arrived while a full vector was waiting.

Function
REQ-013 The block SHALL implement three states: IDLE, COLLECT and FULL.
REQ-014 IDLE: in_valid SHALL be ignored; run SHALL clear the buffer to 0, set cnt=0, clear err_overrun and go to COLLECT.
REQ-015 COLLECT: each in_valid SHALL write in_data to slot cnt and increment cnt (slot 0 is the first word received).
REQ-016 COLLECT: in_valid with cnt==OUT_DIM-1 SHALL write the last slot and go to FULL; valid SHALL be high the next cycle (latency 1 from the last word).
REQ-017 COLLECT: run SHALL restart collection (buffer cleared, cnt=0); an in_valid in the same cycle SHALL be dropped.
REQ-018 The cycle that samples run SHALL never capture a word, in any state.
REQ-019 FULL: valid=1 and data_out SHALL stay stable until out_ready is sampled high.
REQ-020 FULL with out_ready=1 and run=0: next state SHALL be IDLE, and valid SHALL be 0 the following cycle.
REQ-021 FULL with out_ready=1 and run=1: the handshake SHALL complete and the block SHALL enter COLLECT with a cleared buffer and cnt=0.
REQ-022 FULL with out_ready=0: run SHALL be ignored.
REQ-023 FULL: in_valid SHALL drop the word and set err_overrun, which stays high until the next accepted run or reset.
REQ-024 busy SHALL equal (state==COLLECT); valid SHALL equal (state==FULL); both are registered outputs.
REQ-025 cnt SHALL be $clog2(OUT_DIM) bits wide (minimum 1) and SHALL never exceed OUT_DIM-1.
REQ-026 The data_out contents SHALL be held in IDLE after the handshake, and change only on a clear or a slot write.

Reset
REQ-027 While rst_n=0: state=IDLE, cnt=0, data_out=0, valid=0, busy=0, err_overrun=0.
REQ-028 Reset asserted mid-COLLECT or mid-FULL SHALL abandon the partial or pending vector with no output pulse.
REQ-029 On the first clock edge after rst_n rises, only run SHALL change state.

Structure
REQ-030 `HID_DIM, `N_LEN and `DATA_N SHALL come from the shared header consts_trained.vh; the state encoding is local to this module.
REQ-031 The design SHALL be a single flat module with no sub-module: state register, slot counter, per-slot write enables and buffer register.
REQ-032 The slot write SHALL use indexed part-select, with no per-slot hand-written logic.

Verification (OUT_DIM=4, DW=8)
REQ-033 Run, then in_valid on 4 consecutive cycles with words 0x11, 0x22, 0x33, 0x44 and out_ready=1 -> valid exactly 1 cycle, one cycle after 0x44; data_out=0x44332211.
REQ-034 Same 4 words with gaps of 2 idle cycles, then out_ready low for 5 cycles -> valid held 5+ cycles; data_out stable; drops 1 cycle after out_ready=1.
REQ-035 Run, words 0xAA, 0xBB, then run together with in_valid word 0xCC, then words 1, 2, 3, 4 -> data_out=0x04030201; 0xCC is absent.
REQ-036 Vector full, out_ready=0, in_valid word 0x55 -> err_overrun=1; data_out unchanged; err_overrun is cleared by the next accepted run.
REQ-037 Vector full, out_ready=1 and run in the same cycle -> valid=0 and busy=1 next cycle, cnt=0; the next 4 words form a new vector.
REQ-038 rst_n pulsed low after 2 words -> all outputs 0; a subsequent run plus 4 words yields the correct vector.

Source files
------------

// File: rtl/data_out_collect_pkg.sv
// Shared sizing constants and helpers for the result collector.
// Default macros mirror the shared consts_trained.vh values; a build that includes that header first overrides them.
`ifndef HID_DIM
`define HID_DIM 4
`endif
`ifndef N_LEN
`define N_LEN 8
`endif
`ifndef DATA_N
`define DATA_N 16
`endif

package data_out_collect_pkg;

    // Counter width for a given number of slots, never below one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/data_out_collect.sv
// Collects OUT_DIM result words into one vector and hands it downstream.
// Ports: clk, rst_n, run, in_valid, in_data, out_ready -> valid, data_out, busy, err_overrun.
module data_out_collect
    import data_out_collect_pkg::*;
#(
    parameter int OUT_DIM = `HID_DIM,
    parameter int DW      = `N_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_data,
    input  logic                  out_ready,
    output logic                  valid,
    output logic [OUT_DIM*DW-1:0] data_out,
    output logic                  busy,
    output logic                  err_overrun
);

    localparam int CW = cnt_width(OUT_DIM);
    localparam logic [CW-1:0] LAST = CW'(OUT_DIM - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          wr;
    logic          last;

    // A run in the same cycle always wins over a word.
    assign wr   = (state == COLLECT) && in_valid && !run;
    assign last = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            data_out    <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (run) begin
                        data_out    <= '0;
                        cnt         <= '0;
                        err_overrun <= 1'b0;
                        state       <= COLLECT;
                        busy        <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (run) begin
                        data_out    <= '0;
                        cnt         <= '0;
                        err_overrun <= 1'b0;
                    end else if (wr) begin
                        data_out[cnt*DW +: DW] <= in_data;
                        if (last) begin
                            cnt   <= '0;
                            state <= FULL;
                            valid <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    // Word arriving while a vector waits is lost.
                    if (in_valid) begin
                        err_overrun <= 1'b1;
                    end
                    // run only counts once the pending vector is taken.
                    if (out_ready) begin
                        valid <= 1'b0;
                        if (run) begin
                            data_out    <= '0;
                            cnt         <= '0;
                            err_overrun <= 1'b0;
                            state       <= COLLECT;
                            busy        <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
